// File: rtl/tpu_tile_sequencer_if.sv
// Host-side control/status bundle for tpu_tile_sequencer.
// The host drives the master modport; the sequencer uses the slave modport.
interface tpu_tile_sequencer_if #(
  parameter int ADDRESSSIZE   = 10,
  parameter int ADDRESSSIZE_W = 2,
  parameter int TILE_BW       = 8
);
  logic                     start;
  logic                     abort;
  logic [TILE_BW-1:0]       num_tiles;
  logic [ADDRESSSIZE-1:0]   ub_base;
  logic [ADDRESSSIZE-1:0]   res_base;
  logic [ADDRESSSIZE_W-1:0] w_addr;
  logic                     we_rl;
  logic                     ub_rd_en;
  logic [ADDRESSSIZE-1:0]   ub_addr;
  logic                     res_we;
  logic [ADDRESSSIZE-1:0]   res_addr;
  logic                     busy;
  logic                     done;
  logic [TILE_BW-1:0]       tile_idx;
  logic [31:0]              perf_cycles;

  modport master (
    output start, abort, num_tiles, ub_base, res_base,
    input  w_addr, we_rl, ub_rd_en, ub_addr, res_we, res_addr,
           busy, done, tile_idx, perf_cycles
  );

  modport slave (
    input  start, abort, num_tiles, ub_base, res_base,
    output w_addr, we_rl, ub_rd_en, ub_addr, res_we, res_addr,
           busy, done, tile_idx, perf_cycles
  );
endinterface

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer for the systolic core: weight reload, UB streaming and result write window per tile.
// Optional busy-cycle counter enabled by defining TPU_TILE_SEQ_PERF_EN.
module tpu_tile_sequencer #(
  parameter int MATRIX_SIZE   = 64,
  parameter int ADDRESSSIZE   = 10,
  parameter int ADDRESSSIZE_W = 2,
  parameter int TILE_BW       = 8,
  parameter int W_SETTLE      = 1,
  parameter int RES_LAT       = 130
) (
  input  logic                 clk,
  input  logic                 rstn,
  tpu_tile_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LOAD_W, WAIT_W, STREAM, DRAIN, DONE} state_t;

  localparam logic [31:0]            SETTLE_LAST = 32'(W_SETTLE) - 32'd1;
  localparam logic [31:0]            STREAM_LAST = 32'(MATRIX_SIZE - 1);
  localparam logic [31:0]            WR_FIRST    = 32'(RES_LAT);
  localparam logic [31:0]            WR_LAST     = 32'(RES_LAT + MATRIX_SIZE - 1);
  localparam logic [ADDRESSSIZE-1:0] TILE_STRIDE = ADDRESSSIZE'(MATRIX_SIZE);

  state_t                 state_reg;
  logic [31:0]            cnt_reg;       // settle count in WAIT_W, latency counter lc in STREAM/DRAIN
  logic [TILE_BW-1:0]     tile_reg;
  logic [TILE_BW-1:0]     num_tiles_reg;
  logic [ADDRESSSIZE-1:0] ub_base_reg;
  logic [ADDRESSSIZE-1:0] res_base_reg;
  logic [ADDRESSSIZE-1:0] tile_off_reg;  // tile_idx * MATRIX_SIZE, kept incrementally
  logic [TILE_BW:0]       next_tile;
  logic                   busy;
  logic                   res_we;

  assign next_tile = {1'b0, tile_reg} + (TILE_BW+1)'(1);
  assign busy      = (state_reg == LOAD_W) || (state_reg == WAIT_W) ||
                     (state_reg == STREAM) || (state_reg == DRAIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      tile_reg      <= '0;
      num_tiles_reg <= '0;
      ub_base_reg   <= '0;
      res_base_reg  <= '0;
      tile_off_reg  <= '0;
    end else if (busy && bus.abort) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            num_tiles_reg <= bus.num_tiles;
            ub_base_reg   <= bus.ub_base;
            res_base_reg  <= bus.res_base;
            tile_reg      <= '0;
            tile_off_reg  <= '0;
            cnt_reg       <= '0;
            state_reg     <= (bus.num_tiles != '0) ? LOAD_W : DONE;
          end
        end
        LOAD_W: begin
          cnt_reg   <= '0;
          state_reg <= (W_SETTLE == 0) ? STREAM : WAIT_W;
        end
        WAIT_W: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg   <= '0;
            state_reg <= STREAM;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        STREAM: begin
          cnt_reg <= cnt_reg + 32'd1;
          if (cnt_reg == STREAM_LAST) state_reg <= DRAIN;
        end
        DRAIN: begin
          // RES_LAT >= 1 guarantees the last write always lands in DRAIN
          if (cnt_reg == WR_LAST) begin
            cnt_reg <= '0;
            if (next_tile < {1'b0, num_tiles_reg}) begin
              tile_reg     <= next_tile[TILE_BW-1:0];
              tile_off_reg <= tile_off_reg + TILE_STRIDE;
              state_reg    <= LOAD_W;
            end else begin
              state_reg <= DONE;
            end
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign res_we = ((state_reg == STREAM) || (state_reg == DRAIN)) &&
                  (cnt_reg >= WR_FIRST) && (cnt_reg <= WR_LAST);

  assign bus.busy     = busy;
  assign bus.done     = (state_reg == DONE);
  assign bus.we_rl    = (state_reg == LOAD_W);
  assign bus.ub_rd_en = (state_reg == STREAM);
  assign bus.res_we   = res_we;
  assign bus.tile_idx = tile_reg;
  assign bus.w_addr   = tile_reg[ADDRESSSIZE_W-1:0];
  assign bus.ub_addr  = (state_reg == STREAM)
                      ? ub_base_reg + tile_off_reg + cnt_reg[ADDRESSSIZE-1:0] : '0;
  assign bus.res_addr = res_we
                      ? res_base_reg + tile_off_reg + ADDRESSSIZE'(cnt_reg - WR_FIRST) : '0;

`ifdef TPU_TILE_SEQ_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_reg <= '0;
    end else if ((state_reg == IDLE) && bus.start) begin
      perf_reg <= '0;
    end else if (busy && (perf_reg != 32'hFFFF_FFFF)) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_reg;
`else
  assign bus.perf_cycles = '0;
`endif
endmodule
